// File: rtl/operand_stack_ctrl_if.sv
// Bus bundle between the operand stack controller, its requester and the
// 512x16 data memory.
// master : the stack controller (consumes requests, initiates memory accesses)
// slave  : the environment (control unit / ALU sequencer plus the data memory)
//
// Handshake: REQ/OP/DIN are sampled on a posedge only while BUSY=0; BUSY rises
// the cycle after acceptance and stays high through the single-cycle DONE
// pulse; ERR and DOUT are meaningful while DONE=1.
interface operand_stack_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic                 REQ;
  logic [2:0]           OP;
  logic signed [DW-1:0] DIN;
  logic                 BUSY;
  logic                 DONE;
  logic                 ERR;
  logic signed [DW-1:0] DOUT;
  logic [AW:0]          COUNT;
  logic                 FULL;
  logic                 EMPTY;
  logic                 MEM_EN;
  logic [AW-1:0]        MEM_ADDR;
  logic signed [DW-1:0] MEM_IN;
  logic signed [DW-1:0] MEM_OUT;

  modport master (
    input  REQ, OP, DIN, MEM_OUT,
    output BUSY, DONE, ERR, DOUT, COUNT, FULL, EMPTY, MEM_EN, MEM_ADDR, MEM_IN
  );

  modport slave (
    output REQ, OP, DIN, MEM_OUT,
    input  BUSY, DONE, ERR, DOUT, COUNT, FULL, EMPTY, MEM_EN, MEM_ADDR, MEM_IN
  );
endinterface

// File: rtl/operand_stack_ctrl.sv
// RPN operand stack controller for the calculator data memory.
// The stack grows upward from BASE; the top element sits at BASE+COUNT-1.
// Every operation runs IDLE -> A1..A4 (one memory access each) -> FIN.
// Memory controls are decoded only from the registered state and latched
// operands so they are stable from posedge through the write negedge.
module operand_stack_ctrl #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int BASE  = 0,
  parameter int DEPTH = 512
) (
  input  logic                  CLK,
  input  logic                  RST,
  operand_stack_ctrl_if.master  bus,
  output logic [2:0]            DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A1   = 3'd1,
    A2   = 3'd2,
    A3   = 3'd3,
    A4   = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_PEEK  = 3'b011;
  localparam logic [2:0] OP_SWAP  = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [AW:0] BASE_W  = (AW+1)'(BASE);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] TWO     = (AW+1)'(2);

  state_t               state_q, state_d;
  logic [2:0]           op_q;
  logic signed [DW-1:0] din_q;
  logic signed [DW-1:0] tmp_a;
  logic signed [DW-1:0] tmp_b;
  logic signed [DW-1:0] dout_q;
  logic [AW:0]          count_q;
  logic                 err_q;

  logic                 full, empty;
  logic                 err_c;
  logic                 mem_en_c;
  logic [AW:0]          addr_w;
  logic signed [DW-1:0] mem_in_c;
  logic                 unused_addr_msb;

  // Stack pointers in AW+1 bits; the FULL/EMPTY checks keep them in range.
  logic [AW:0] push_ptr, top_ptr, sec_ptr;
  assign push_ptr = BASE_W + count_q;
  assign top_ptr  = BASE_W + count_q - ONE;
  assign sec_ptr  = BASE_W + count_q - TWO;

  assign full  = (count_q == DEPTH_W);
  assign empty = (count_q == '0);

  // State register; async reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, request validation and memory-access decode.
  always_comb begin
    state_d  = state_q;
    err_c    = 1'b0;
    mem_en_c = 1'b0;
    addr_w   = '0;
    mem_in_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          case (bus.OP)
            OP_NOP:   err_c = 1'b0;
            OP_CLEAR: err_c = 1'b0;
            OP_PUSH:  err_c = full;
            OP_POP:   err_c = empty;
            OP_PEEK:  err_c = empty;
            OP_DUP:   err_c = full | empty;
            OP_SWAP:  err_c = (count_q < TWO);
            default:  err_c = 1'b1;
          endcase
          if (err_c || bus.OP == OP_NOP || bus.OP == OP_CLEAR) state_d = FIN;
          else                                                 state_d = A1;
        end
      end
      A1: begin
        case (op_q)
          OP_PUSH: begin
            mem_en_c = 1'b1;
            addr_w   = push_ptr;
            mem_in_c = din_q;
            state_d  = FIN;
          end
          OP_POP, OP_PEEK: begin
            addr_w  = top_ptr;
            state_d = FIN;
          end
          OP_DUP, OP_SWAP: begin
            addr_w  = top_ptr;
            state_d = A2;
          end
          default: state_d = FIN;
        endcase
      end
      A2: begin
        if (op_q == OP_DUP) begin
          mem_en_c = 1'b1;
          addr_w   = push_ptr;
          mem_in_c = tmp_a;
          state_d  = FIN;
        end else begin
          addr_w  = sec_ptr;
          state_d = A3;
        end
      end
      A3: begin
        mem_en_c = 1'b1;
        addr_w   = sec_ptr;
        mem_in_c = tmp_a;
        state_d  = A4;
      end
      A4: begin
        mem_en_c = 1'b1;
        addr_w   = top_ptr;
        mem_in_c = tmp_b;
        state_d  = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, read capture, stack count and result register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q    <= OP_NOP;
      din_q   <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
      dout_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.REQ) begin
            op_q  <= bus.OP;
            din_q <= bus.DIN;
            err_q <= err_c;
            if (bus.OP == OP_CLEAR) count_q <= '0;
          end
        end
        A1: begin
          case (op_q)
            OP_PUSH: count_q <= count_q + ONE;
            OP_POP: begin
              dout_q  <= bus.MEM_OUT;
              count_q <= count_q - ONE;
            end
            OP_PEEK:         dout_q <= bus.MEM_OUT;
            OP_DUP, OP_SWAP: tmp_a  <= bus.MEM_OUT;
            default: ;
          endcase
        end
        A2: begin
          if (op_q == OP_DUP) begin
            dout_q  <= tmp_a;
            count_q <= count_q + ONE;
          end else begin
            tmp_b <= bus.MEM_OUT;
          end
        end
        A4:      dout_q <= tmp_b;
        default: ;
      endcase
    end
  end

  assign unused_addr_msb = addr_w[AW];

  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = (state_q == FIN);
  assign bus.ERR      = (state_q == FIN) & err_q;
  assign bus.DOUT     = dout_q;
  assign bus.COUNT    = count_q;
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.MEM_EN   = mem_en_c;
  assign bus.MEM_ADDR = addr_w[AW-1:0];
  assign bus.MEM_IN   = mem_in_c;
  assign DBG_STATE    = state_q;

endmodule

// File: doc/operand_stack_ctrl.md
Name: operand_stack_ctrl

Overview:
- Initiator-side controller for the calculator's 512x16 signed data memory.
- Implements an RPN operand stack (push/pop/peek/dup/swap/clear) for the calculator datapath over a single request/done handshake.
- Drives the memory's address, write-data and write-enable lines; consumes its combinational read data.
- Sits between the control unit / ALU sequencer and the data memory.

Parameters:
- AW, 9, memory address width.
- DW, 16, data width (signed two's complement).
- BASE, 0, first memory address of the stack region.
- DEPTH, 512, maximum number of stacked operands; BASE+DEPTH must not exceed 2^AW.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous active-low reset.
- REQ  in  1  operation request, sampled only while BUSY=0.
- OP  in  3  000 NOP, 001 PUSH, 010 POP, 011 PEEK, 100 SWAP, 101 DUP, 110 CLEAR, 111 illegal.
- DIN  in  DW  signed operand for PUSH.
- BUSY  out  1  high from the cycle after acceptance through the DONE cycle inclusive.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = operation rejected.
- DOUT  out  DW  signed result register.
- COUNT  out  AW+1  number of stacked operands.
- FULL  out  1  COUNT==DEPTH.
- EMPTY  out  1  COUNT==0.
- MEM_EN  out  1  memory write enable; memory writes on negedge CLK.
- MEM_ADDR  out  AW  memory address.
- MEM_IN  out  DW  memory write data.
- MEM_OUT  in  DW  memory read data (combinational from MEM_ADDR).

Behaviour:
- Reset (RST=0, async):
  - State IDLE; COUNT=0.
  - DOUT, MEM_ADDR and MEM_IN = 0.
  - BUSY, DONE, ERR and MEM_EN = 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts it; MEM_EN drops immediately; no DONE is issued.
- Stack layout: grows upward; the top element is at BASE+COUNT-1; a push goes to BASE+COUNT.
- FSM states: IDLE, A1, A2, A3, A4, FIN.
  - IDLE + REQ at posedge latches OP and DIN and moves to A1, or straight to FIN for CLEAR, NOP and error cases.
  - Each An is exactly one access cycle.
  - FIN asserts DONE for one cycle, then returns to IDLE.
  - REQ is ignored when not in IDLE; a new request is accepted in the cycle after FIN.
- Memory timing:
  - MEM_ADDR, MEM_IN and MEM_EN are decoded only from registered state and latched operands, never from REQ or DIN directly.
  - They are stable from posedge through the following negedge.
  - Read cycles: MEM_EN=0; MEM_OUT is sampled at the closing posedge.
- Operation sequences (request-to-DONE latency = access cycles + 1):
  - PUSH: A1 writes DIN at BASE+COUNT; COUNT+1. Latency 2.
  - POP: A1 reads the top into DOUT; COUNT-1. Latency 2.
  - PEEK: A1 reads the top into DOUT; COUNT unchanged. Latency 2.
  - DUP: A1 reads the top into a temp register; A2 writes the temp at BASE+COUNT; COUNT+1; DOUT = the duplicated value. Latency 3.
  - SWAP: A1 reads top (a); A2 reads top-1 (b); A3 writes a at top-1; A4 writes b at top; DOUT = b. Latency 5.
  - CLEAR: COUNT=0, no memory access. Latency 1.
  - NOP: no effect. Latency 1.
- COUNT changes at the posedge ending the last access cycle. FULL and EMPTY are combinational from COUNT.
- Errors (ERR=1 with DONE, latency 1): no memory access; COUNT and DOUT unchanged. Error cases:
  - PUSH or DUP when FULL.
  - POP, PEEK or DUP when EMPTY.
  - SWAP when COUNT<2.
  - OP=111.
- ERR=0 whenever DONE=0.
- Arithmetic: address = BASE + COUNT (or COUNT-1 / COUNT-2), computed in AW+1 bits, then truncated to AW. No wrap occurs because the FULL/EMPTY checks precede every access.

Test Plan:
- Reset with COUNT=0 -> all outputs 0; EMPTY=1, FULL=0.
- PUSH 16'sd5, then PUSH -16'sd3 -> each DONE 2 cycles after REQ; memory[0]=5, memory[1]=0xFFFD; COUNT=2.
- SWAP -> DONE 5 cycles after REQ; memory[0]=0xFFFD, memory[1]=5; DOUT=5; MEM_EN high only in A3 and A4.
- POP twice, then POP again -> DOUT=5, then -3; COUNT goes to 0; third POP gives DONE with ERR=1, COUNT stays 0, MEM_EN never high.
- DEPTH=4 build: 4 PUSHes, then PUSH 7 -> FULL=1; fifth gives ERR=1, memory[4] untouched; DUP also ERR=1.
- Assert RST low during A2 of a SWAP -> MEM_EN=0 immediately, COUNT=0, no DONE; next PUSH 9 writes memory[0]=9.
